priority_dec_v: RTL and testbench

- Sequential decoder paired with the team's priority encoders: turns an encoded select code back into a one-hot drive vector.
- Accepts codes over a valid/ready handshake and drives each one-hot pattern for a programmable number of cycles.
- Inserts an all-zero break-before-make gap between consecutive patterns and buffers one pending code.
- Sits between control logic and one-hot consumers (mux selects, LED/segment enables).

---
 rtl/priority_dec_v_pkg.sv | 18 +
 rtl/dec_onehot_v.sv | 18 +
 rtl/priority_dec_v.sv | 149 ++++++++++++++
 tb/tb_priority_dec_v.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/priority_dec_v_pkg.sv
// Shared definitions for the one-hot drive sequencer: state encoding and
// counter sizing.
package priority_dec_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Wide enough to hold the larger of the two reload values.
    function automatic int cnt_width(input int hold, input int gap);
        int longest;
        longest = (hold > gap) ? hold : gap;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/dec_onehot_v.sv
// Combinational code-to-one-hot decoder; in_range is low (and onehot all-zero)
// for codes that have no corresponding output bit.
module dec_onehot_v #(
    parameter int N_OUT  = 4,
    parameter int W_CODE = 2
) (
    input  logic [W_CODE-1:0] code,
    output logic [N_OUT-1:0]  onehot,
    output logic              in_range
);

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_bit
        assign onehot[gi] = (code == W_CODE'(gi));
    end

    assign in_range = |onehot;

endmodule

// File: rtl/priority_dec_v.sv
// Drives one-hot patterns for HOLD cycles each from codes accepted over a
// valid/ready handshake, with a GAP-cycle all-zero break and one pending slot.
module priority_dec_v
    import priority_dec_v_pkg::*;
#(
    parameter int N_OUT = 4,
    parameter int HOLD  = 3,
    parameter int GAP   = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [$clog2(N_OUT)-1:0]   i_code,
    output logic [N_OUT-1:0]           o_onehot,
    output logic                       o_active,
    output logic                       o_err
);

    localparam int W_CODE = $clog2(N_OUT);
    localparam int CW     = cnt_width(HOLD, GAP);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t              state_reg, state_next;
    logic [W_CODE-1:0]   drive_code_reg, drive_code_next;
    logic                buf_valid_reg, buf_valid_next;
    logic [W_CODE-1:0]   buf_code_reg, buf_code_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic                ready_reg, ready_next;
    logic [N_OUT-1:0]    onehot_reg, onehot_next;
    logic                active_reg, active_next;
    logic                err_reg, err_next;

    logic                accept, take, code_legal;
    logic [W_CODE-1:0]   pend_code;
    logic [N_OUT-1:0]    drive_dec;
    logic [N_OUT-1:0]    unused_chk_onehot;
    logic                unused_out_in_range;

    dec_onehot_v #(.N_OUT(N_OUT), .W_CODE(W_CODE)) u_chk (
        .code     (i_code),
        .onehot   (unused_chk_onehot),
        .in_range (code_legal)
    );

    dec_onehot_v #(.N_OUT(N_OUT), .W_CODE(W_CODE)) u_out (
        .code     (drive_code_next),
        .onehot   (drive_dec),
        .in_range (unused_out_in_range)
    );

    always_comb begin
        accept          = i_valid && ready_reg;
        take            = accept && code_legal;
        state_next      = state_reg;
        drive_code_next = drive_code_reg;
        buf_valid_next  = buf_valid_reg;
        buf_code_next   = buf_code_reg;
        cnt_next        = cnt_reg;
        pend_code       = buf_valid_reg ? buf_code_reg : i_code;

        case (state_reg)
            ST_IDLE: begin
                if (take) begin
                    state_next      = ST_DRIVE;
                    drive_code_next = i_code;
                    cnt_next        = HOLD_LOAD;
                end
            end
            ST_DRIVE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                    if (take) begin
                        buf_valid_next = 1'b1;
                        buf_code_next  = i_code;
                    end
                end else if (buf_valid_reg || take) begin
                    // A code arriving on the final edge counts as pending.
                    if (GAP > 0) begin
                        state_next     = ST_GAP;
                        cnt_next       = GAP_LOAD;
                        buf_valid_next = 1'b1;
                        buf_code_next  = pend_code;
                    end else begin
                        state_next      = ST_DRIVE;
                        drive_code_next = pend_code;
                        cnt_next        = HOLD_LOAD;
                        buf_valid_next  = 1'b0;
                    end
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end else begin
                    state_next      = ST_DRIVE;
                    drive_code_next = buf_code_reg;
                    cnt_next        = HOLD_LOAD;
                    buf_valid_next  = take;
                    buf_code_next   = take ? i_code : buf_code_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        ready_next  = (state_next == ST_IDLE) || !buf_valid_next;
        onehot_next = (state_next == ST_DRIVE) ? drive_dec : '0;
        active_next = |onehot_next;
        err_next    = accept && !code_legal;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            drive_code_reg <= '0;
            buf_valid_reg  <= 1'b0;
            buf_code_reg   <= '0;
            cnt_reg        <= '0;
            ready_reg      <= 1'b0;
            onehot_reg     <= '0;
            active_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            drive_code_reg <= drive_code_next;
            buf_valid_reg  <= buf_valid_next;
            buf_code_reg   <= buf_code_next;
            cnt_reg        <= cnt_next;
            ready_reg      <= ready_next;
            onehot_reg     <= onehot_next;
            active_reg     <= active_next;
            err_reg        <= err_next;
        end
    end

    assign o_ready  = ready_reg;
    assign o_onehot = onehot_reg;
    assign o_active = active_reg;
    assign o_err    = err_reg;

endmodule

// File: tb/tb_priority_dec_v.sv
// Directed bench: three instances cover GAP=1, GAP=0 and a non-power-of-two
// width with an unused code.
module tb_priority_dec_v;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic [1:0] code_a = '0, code_b = '0;
    logic [2:0] code_c = '0;
    logic       ready_a, ready_b, ready_c;
    logic [3:0] onehot_a, onehot_b;
    logic [4:0] onehot_c;
    logic       active_a, active_b, active_c;
    logic       err_a, err_b, err_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_dec_v #(.N_OUT(4), .HOLD(3), .GAP(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .o_ready(ready_a),
        .i_code(code_a), .o_onehot(onehot_a), .o_active(active_a), .o_err(err_a)
    );

    priority_dec_v #(.N_OUT(4), .HOLD(3), .GAP(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .o_ready(ready_b),
        .i_code(code_b), .o_onehot(onehot_b), .o_active(active_b), .o_err(err_b)
    );

    priority_dec_v #(.N_OUT(5), .HOLD(3), .GAP(1)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_c), .o_ready(ready_c),
        .i_code(code_c), .o_onehot(onehot_c), .o_active(active_c), .o_err(err_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_a = 1'b1; code_a = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (onehot_a !== 4'b0000) begin n_bad++; $display("FAIL reset_onehot: got %b expected 0000", onehot_a); end
            n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ready_a); end
            n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err_a); end
        end
        rst_n = 1'b1; valid_a = 1'b0;
        #1;
        n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL release_ready_early: got %b expected 0", ready_a); end
        tick();
        n_cmp++; if ({ready_a, ready_b, ready_c} !== 3'b111) begin n_bad++; $display("FAIL release_ready: got %b expected 111", {ready_a, ready_b, ready_c}); end
        n_cmp++; if (onehot_a !== 4'b0000) begin n_bad++; $display("FAIL release_onehot: got %b expected 0000", onehot_a); end
        $display("reset: done, %0d compared so far", n_cmp);
    endtask

    task automatic test_single();
        valid_a = 1'b1; code_a = 2'd2;
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (onehot_a !== 4'b0100) begin n_bad++; $display("FAIL single_onehot[%0d]: got %b expected 0100", i, onehot_a); end
            n_cmp++; if (active_a !== 1'b1) begin n_bad++; $display("FAIL single_active[%0d]: got %b expected 1", i, active_a); end
            n_cmp++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL single_ready[%0d]: got %b expected 1", i, ready_a); end
            tick();
        end
        n_cmp++; if ({onehot_a, active_a, ready_a} !== 6'b0000_0_1) begin n_bad++; $display("FAIL single_idle: got %b expected 000001", {onehot_a, active_a, ready_a}); end
        $display("single: code 2 driven, %0d compared so far", n_cmp);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_a [8];
        logic [3:0] exp_b [8];
        logic       rdy_a [8];
        logic       rdy_b [8];
        exp_a = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        exp_b = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        rdy_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rdy_b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        valid_a = 1'b1; code_a = 2'd1; valid_b = 1'b1; code_b = 2'd1;
        tick();
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (onehot_a !== exp_a[k]) begin n_bad++; $display("FAIL b2b_gap1_onehot[%0d]: got %b expected %b", k, onehot_a, exp_a[k]); end
            n_cmp++; if (ready_a !== rdy_a[k]) begin n_bad++; $display("FAIL b2b_gap1_ready[%0d]: got %b expected %b", k, ready_a, rdy_a[k]); end
            n_cmp++; if (active_a !== (exp_a[k] != 4'b0000)) begin n_bad++; $display("FAIL b2b_gap1_active[%0d]: got %b", k, active_a); end
            n_cmp++; if (onehot_b !== exp_b[k]) begin n_bad++; $display("FAIL b2b_gap0_onehot[%0d]: got %b expected %b", k, onehot_b, exp_b[k]); end
            n_cmp++; if (ready_b !== rdy_b[k]) begin n_bad++; $display("FAIL b2b_gap0_ready[%0d]: got %b expected %b", k, ready_b, rdy_b[k]); end
            if (k == 0) begin
                code_a = 2'd3; code_b = 2'd3;
            end else begin
                valid_a = 1'b0; valid_b = 1'b0;
            end
            tick();
        end
        $display("back_to_back: codes 1,3 with GAP=1 and GAP=0, %0d compared so far", n_cmp);
    endtask

    task automatic test_illegal();
        valid_c = 1'b1; code_c = 3'd6;
        tick();
        valid_c = 1'b0;
        n_cmp++; if (err_c !== 1'b1) begin n_bad++; $display("FAIL illegal_err_pulse: got %b expected 1", err_c); end
        n_cmp++; if (onehot_c !== 5'b00000) begin n_bad++; $display("FAIL illegal_onehot: got %b expected 00000", onehot_c); end
        n_cmp++; if (ready_c !== 1'b1) begin n_bad++; $display("FAIL illegal_ready: got %b expected 1", ready_c); end
        tick();
        n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL illegal_err_clear: got %b expected 0", err_c); end
        n_cmp++; if (onehot_c !== 5'b00000) begin n_bad++; $display("FAIL illegal_onehot_after: got %b expected 00000", onehot_c); end
        valid_c = 1'b1; code_c = 3'd4;
        tick();
        valid_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (onehot_c !== 5'b10000) begin n_bad++; $display("FAIL legal4_onehot[%0d]: got %b expected 10000", i, onehot_c); end
            n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL legal4_err[%0d]: got %b expected 0", i, err_c); end
            tick();
        end
        n_cmp++; if (onehot_c !== 5'b00000) begin n_bad++; $display("FAIL legal4_end: got %b expected 00000", onehot_c); end
        $display("illegal: code 6 rejected, code 4 driven, %0d compared so far", n_cmp);
    endtask

    task automatic test_reset_mid();
        valid_a = 1'b1; code_a = 2'd1;
        tick();
        code_a = 2'd2;
        tick();
        valid_a = 1'b0;
        n_cmp++; if ({onehot_a, ready_a} !== 5'b0010_0) begin n_bad++; $display("FAIL midrst_pre: got %b expected 00100", {onehot_a, ready_a}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({onehot_a, active_a, ready_a} !== 6'b0) begin n_bad++; $display("FAIL midrst_async_clear: got %b expected 000000", {onehot_a, active_a, ready_a}); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", ready_a); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (onehot_a !== 4'b0000) begin n_bad++; $display("FAIL midrst_no_resume[%0d]: got %b expected 0000", i, onehot_a); end
            tick();
        end
        $display("reset_mid: buffered code discarded, %0d compared so far", n_cmp);
    endtask

    task automatic test_stall();
        int xfers;
        int run;
        logic [3:0] exp;
        xfers = 0;
        run = 0;
        valid_a = 1'b1; code_a = 2'd0;
        for (int k = 0; k < 20; k++) begin
            if (valid_a && ready_a) xfers++;
            tick();
            // Steady state with continuous offers: 3 drive cycles then 1 gap cycle.
            exp = (k % 4 == 3) ? 4'b0000 : 4'b0001;
            n_cmp++; if (onehot_a !== exp) begin n_bad++; $display("FAIL stall_onehot[%0d]: got %b expected %b", k, onehot_a, exp); end
            n_cmp++; if (!$onehot0(onehot_a)) begin n_bad++; $display("FAIL stall_onehot0[%0d]: got %b expected at most one bit", k, onehot_a); end
            if (onehot_a != 4'b0000) begin
                run++;
            end else begin
                n_cmp++; if (run !== 3) begin n_bad++; $display("FAIL stall_hold_len[%0d]: got %0d expected 3", k, run); end
                run = 0;
            end
        end
        valid_a = 1'b0;
        n_cmp++; if (xfers !== 6) begin n_bad++; $display("FAIL stall_transfers: got %0d expected 6", xfers); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if ({onehot_a, ready_a} !== 5'b0000_1) begin n_bad++; $display("FAIL stall_drain: got %b expected 00001", {onehot_a, ready_a}); end
        $display("stall: %0d transfers in 20 cycles, %0d compared so far", xfers, n_cmp);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
